// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared types for the writeback stage and its long-latency FIFO
package writeback_unit_pkg;
   typedef struct packed {
      logic        wb_valid;
      logic [4:0]  wb_waddr;
      logic [31:0] wb_wdata;
      logic        ll_valid;
      logic [4:0]  ll_waddr;
      logic [31:0] ll_wdata;
      logic        iss_valid;
      logic        iss_long;
      logic [4:0]  iss_waddr;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [4:0]  raddrd;
   } writeback_in_type;
   typedef struct packed {
      logic wb_stall;
      logic ll_ready;
      logic busy1;
      logic busy2;
      logic busyd;
   } writeback_out_type;
   typedef struct packed {
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } fifo_entry_type;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: request/status bundle plus the register file write port
interface writeback_unit_if;
   writeback_unit_pkg::writeback_in_type  i;
   writeback_unit_pkg::writeback_out_type o;
   logic        wren;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   modport master (output i, input o, wren, waddr, wdata);
   modport slave  (input i, output o, wren, waddr, wdata);
endinterface

// File: rtl/writeback_unit_fifo.sv
// writeback_fifo: small FIFO for long-latency results; reset clears pointers only
module writeback_fifo
   import writeback_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  fifo_entry_type din,
   output fifo_entry_type dout,
   output logic           full,
   output logic           empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]  wp, rp;
   logic [AW:0]    cnt;
   fifo_entry_type mem [DEPTH];
   assign full  = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout  = mem[rp];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wp + AW'(push);
         rp  <= rp + AW'(pop);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges pipeline and long-latency results into one register file write port
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   writeback_unit_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   writeback_in_type d;
   fifo_entry_type   head, sel_e, ll_e;
   logic             push, pop, full, empty, drain, sel_pipe, sel, out_long;
   logic             wren;
   logic [4:0]       waddr;
   logic [31:0]      wdata, pending, set_m, clr_m;
   logic [SW-1:0]    scnt;
   assign d        = bus.i;
   assign drain    = scnt == SW'(STARVE_LIMIT) && !empty;
   assign pop      = !empty && (drain || !d.wb_valid);
   assign sel_pipe = d.wb_valid && !drain;
   assign sel      = sel_pipe || pop;
   assign sel_e    = sel_pipe ? fifo_entry_type'{d.wb_waddr, d.wb_wdata} : head;
   assign ll_e     = fifo_entry_type'{d.ll_waddr, d.ll_wdata};
   assign push     = d.ll_valid && !full;
   assign set_m    = (d.iss_valid && d.iss_long) ? 32'd1 << d.iss_waddr : 32'd0;
   assign clr_m    = (wren && out_long) ? 32'd1 << waddr : 32'd0;
   assign bus.o    = writeback_out_type'{drain, !full, pending[d.raddr1], pending[d.raddr2], pending[d.raddrd]};
   assign bus.wren  = wren;
   assign bus.waddr = waddr;
   assign bus.wdata = wdata;
   writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (ll_e),
      .dout (head),
      .full (full),
      .empty(empty)
   );
   // x0 writes are consumed but leave waddr/wdata untouched
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wren     <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         out_long <= 1'b0;
      end else begin
         wren     <= sel && sel_e.waddr != '0;
         out_long <= pop;
         if (sel && sel_e.waddr != '0) begin
            waddr <= sel_e.waddr;
            wdata <= sel_e.wdata;
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) scnt <= '0;
      else if (empty || pop) scnt <= '0;
      else if (d.wb_valid && scnt != SW'(STARVE_LIMIT)) scnt <= scnt + 1'b1;
   // set after clear so a same-cycle reissue keeps the bit
   always_ff @(posedge clk or posedge rst)
      if (rst) pending <= '0;
      else pending <= ((pending & ~clr_m) | set_m) & 32'hFFFF_FFFE;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of writeback selection, starvation drain, scoreboard and reset
module tb_writeback_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   writeback_unit_if bus ();
   writeback_unit #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.i = '0;
      #3;
      chk("rst_wren", 32'(bus.wren), 0);
      chk("rst_waddr", 32'(bus.waddr), 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_ll_ready", 32'(bus.o.ll_ready), 1);
      chk("rst_wb_stall", 32'(bus.o.wb_stall), 0);
      #9 rst = 1'b0;
      step;
      // pipeline write latency
      bus.i.wb_valid = 1'b1;
      bus.i.wb_waddr = 5'd5;
      bus.i.wb_wdata = 32'hDEADBEEF;
      step;
      bus.i.wb_valid = 1'b0;
      chk("wb_wren", 32'(bus.wren), 1);
      chk("wb_waddr", 32'(bus.waddr), 5);
      chk("wb_wdata", bus.wdata, 32'hDEADBEEF);
      step;
      chk("wb_wren_off", 32'(bus.wren), 0);
      chk("wb_waddr_hold", 32'(bus.waddr), 5);
      // long-latency with scoreboard
      bus.i.iss_valid = 1'b1;
      bus.i.iss_long = 1'b1;
      bus.i.iss_waddr = 5'd7;
      bus.i.raddrd = 5'd7;
      bus.i.raddr1 = 5'd7;
      #1 chk("ll_busy_c1", 32'(bus.o.busyd), 0);
      step;
      bus.i.iss_valid = 1'b0;
      #1 chk("ll_busy_c2", 32'(bus.o.busyd), 1);
      chk("ll_busy1_c2", 32'(bus.o.busy1), 1);
      step;
      bus.i.ll_valid = 1'b1;
      bus.i.ll_waddr = 5'd7;
      bus.i.ll_wdata = 32'h12345678;
      #1 chk("ll_busy_c3", 32'(bus.o.busyd), 1);
      step;
      bus.i.ll_valid = 1'b0;
      #1 chk("ll_busy_c4", 32'(bus.o.busyd), 1);
      chk("ll_wren_c4", 32'(bus.wren), 0);
      step;
      chk("ll_wren_c5", 32'(bus.wren), 1);
      chk("ll_waddr_c5", 32'(bus.waddr), 7);
      chk("ll_wdata_c5", bus.wdata, 32'h12345678);
      chk("ll_busy_c5", 32'(bus.o.busyd), 1);
      step;
      chk("ll_busy_c6", 32'(bus.o.busyd), 0);
      // starvation drain with a full FIFO
      bus.i.wb_valid = 1'b1;
      bus.i.wb_waddr = 5'd1;
      bus.i.wb_wdata = 32'h100;
      for (int k = 0; k < 4; k++) begin
         bus.i.ll_valid = 1'b1;
         bus.i.ll_waddr = 5'(10 + k);
         bus.i.ll_wdata = 32'hA0 + 32'(k);
         #1 chk("fill_ready", 32'(bus.o.ll_ready), 1);
         step;
      end
      bus.i.ll_waddr = 5'd14;
      bus.i.ll_wdata = 32'hA4;
      #1;
      for (int c = 5; c <= 10; c++) begin
         chk("full_ready", 32'(bus.o.ll_ready), 0);
         chk("starve_stall", 32'(bus.o.wb_stall), 32'(c == 10));
         step;
      end
      chk("drain_wren", 32'(bus.wren), 1);
      chk("drain_waddr", 32'(bus.waddr), 10);
      chk("drain_wdata", bus.wdata, 32'hA0);
      chk("drain_ready", 32'(bus.o.ll_ready), 1);
      step;
      bus.i.ll_valid = 1'b0;
      bus.i.wb_valid = 1'b0;
      #1 chk("refill_ready", 32'(bus.o.ll_ready), 0);
      chk("after_drain_wb", 32'(bus.waddr), 1);
      step;
      for (int k = 1; k <= 4; k++) begin
         chk("order_waddr", 32'(bus.waddr), 32'(10 + k));
         chk("order_wdata", bus.wdata, 32'hA0 + 32'(k));
         step;
      end
      chk("empty_wren", 32'(bus.wren), 0);
      // x0 writes are swallowed
      bus.i.wb_valid = 1'b1;
      bus.i.wb_waddr = 5'd0;
      bus.i.wb_wdata = 32'h55;
      bus.i.ll_valid = 1'b1;
      bus.i.ll_waddr = 5'd0;
      bus.i.ll_wdata = 32'h66;
      bus.i.iss_valid = 1'b1;
      bus.i.iss_waddr = 5'd0;
      bus.i.raddr1 = 5'd0;
      #1 chk("x0_busy_c1", 32'(bus.o.busy1), 0);
      step;
      bus.i = '0;
      chk("x0_wren_c2", 32'(bus.wren), 0);
      chk("x0_busy_c2", 32'(bus.o.busy1), 0);
      step;
      chk("x0_wren_c3", 32'(bus.wren), 0);
      chk("x0_waddr_hold", 32'(bus.waddr), 14);
      chk("x0_ready", 32'(bus.o.ll_ready), 1);
      step;
      chk("x0_wren_c4", 32'(bus.wren), 0);
      // same-cycle set and clear of x9
      bus.i.iss_valid = 1'b1;
      bus.i.iss_long = 1'b1;
      bus.i.iss_waddr = 5'd9;
      bus.i.raddrd = 5'd9;
      step;
      bus.i.iss_valid = 1'b0;
      bus.i.ll_valid = 1'b1;
      bus.i.ll_waddr = 5'd9;
      bus.i.ll_wdata = 32'h99;
      step;
      bus.i.ll_valid = 1'b0;
      step;
      chk("x9_wren", 32'(bus.wren), 1);
      chk("x9_waddr", 32'(bus.waddr), 9);
      bus.i.iss_valid = 1'b1;
      step;
      bus.i.iss_valid = 1'b0;
      #1 chk("x9_set_wins", 32'(bus.o.busyd), 1);
      bus.i.ll_valid = 1'b1;
      bus.i.ll_wdata = 32'h98;
      step;
      bus.i.ll_valid = 1'b0;
      step;
      chk("x9_second_wdata", bus.wdata, 32'h98);
      chk("x9_busy_pre", 32'(bus.o.busyd), 1);
      step;
      chk("x9_busy_clear", 32'(bus.o.busyd), 0);
      // asynchronous reset with queued entries and pending bits
      bus.i.iss_valid = 1'b1;
      bus.i.iss_waddr = 5'd3;
      bus.i.raddr1 = 5'd3;
      bus.i.raddr2 = 5'd4;
      bus.i.raddrd = 5'd20;
      step;
      bus.i.iss_waddr = 5'd4;
      step;
      bus.i.iss_valid = 1'b0;
      bus.i.wb_valid = 1'b1;
      bus.i.wb_waddr = 5'd1;
      bus.i.wb_wdata = 32'h77;
      for (int k = 0; k < 3; k++) begin
         bus.i.ll_valid = 1'b1;
         bus.i.ll_waddr = 5'(20 + k);
         bus.i.ll_wdata = 32'hC0 + 32'(k);
         step;
      end
      bus.i.ll_valid = 1'b0;
      #1 chk("prerst_busy1", 32'(bus.o.busy1), 1);
      chk("prerst_busy2", 32'(bus.o.busy2), 1);
      chk("prerst_wren", 32'(bus.wren), 1);
      #1 rst = 1'b1;
      #1 chk("arst_wren", 32'(bus.wren), 0);
      chk("arst_waddr", 32'(bus.waddr), 0);
      chk("arst_ready", 32'(bus.o.ll_ready), 1);
      chk("arst_busy1", 32'(bus.o.busy1), 0);
      chk("arst_busy2", 32'(bus.o.busy2), 0);
      chk("arst_stall", 32'(bus.o.wb_stall), 0);
      bus.i.wb_valid = 1'b0;
      #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step;
         chk("post_rst_wren", 32'(bus.wren), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
